load_use_stall_unit: RTL and testbench
======================================

# load_use_stall_unit

Pipeline stall and freeze controller for the 5-stage MIPS core. It sits beside the ID/EX/MEM pipeline registers. It detects load-use hazards that forwarding cannot cover and inserts one bubble for each. It also freezes the whole pipeline while a variable-latency data memory has not completed a MEM-stage access. The store-data case (load followed by sw using the loaded register as Rt data) is exempt from stalling, because WB→MEM store forwarding already covers it.

## Interface
- WAIT_MAX, 255: wait-state cycle count after which `mem_timeout` is raised.
- CNT_W, 32: width of the stall performance counter.
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous to `clk`, active-high.
- D_Rs  input  5  Rs of the instruction in ID.
- D_Rt  input  5  Rt of the instruction in ID.
- D_UseRs  input  1  ID instruction reads Rs.
- D_UseRt  input  1  ID instruction reads Rt.
- D_MemWr  input  1  ID instruction is a store; its Rt is store data only.
- E_MemRd  input  1  EX instruction is a load.
- E_Rw  input  5  destination register of the EX instruction.
- M_MemRd  input  1  MEM instruction is a load.
- M_MemWr  input  1  MEM instruction is a store.
- mem_ready  input  1  data memory has completed the current access (sampled with MEM_WAIT_EN only).
- PC_Wr  output  1  PC write enable.
- IF_ID_Wr  output  1  IF/ID register write enable.
- ID_EX_Flush  output  1  load a bubble into ID/EX.
- ID_EX_Wr  output  1  ID/EX register write enable.
- EX_MEM_Wr  output  1  EX/MEM register write enable.
- MEM_WB_Flush  output  1  load a bubble into MEM/WB.
- mem_timeout  output  1  sticky wait-timeout flag.
- stall_cycles  output  CNT_W  saturating count of stalled cycles.

## Operation
- `lu_hazard` = E_MemRd && E_Rw≠0 && ((D_UseRs && D_Rs==E_Rw) || (D_UseRt && !D_MemWr && D_Rt==E_Rw)).
- `mem_busy` = (M_MemRd || M_MemWr) && !mem_ready. It is forced to 0 without MEM_WAIT_EN.
- FSM states are RUN and WAIT.
  - RUN→WAIT when `mem_busy`.
  - WAIT→RUN on the first cycle with `mem_ready`=1.
  - WAIT→WAIT otherwise.
- Freeze condition: (state==RUN && mem_busy) || (state==WAIT && !mem_ready). During freeze:
  - PC_Wr, IF_ID_Wr, ID_EX_Wr and EX_MEM_Wr are all 0.
  - MEM_WB_Flush=1.
  - ID_EX_Flush=0.
  - `lu_hazard` is ignored.
- Otherwise, if `lu_hazard`: PC_Wr=0, IF_ID_Wr=0, ID_EX_Flush=1. All other enables are 1.
- Otherwise all enables are 1 and both flushes are 0.
- Freeze has priority over load-use. A load-use hazard that is still present after the freeze releases is handled on that release cycle.
- `wait_cnt` (8-bit minimum, sized for WAIT_MAX):
  - Cleared in RUN.
  - Increments on each WAIT cycle and saturates at WAIT_MAX.
  - When it reaches WAIT_MAX, `mem_timeout` is set to 1 and stays set until `rst`.
  - The pipeline stays frozen until `mem_ready`.
- `stall_cycles` increments by 1 on each cycle where freeze or `lu_hazard` stalls the PC. It saturates at all-ones and does not wrap.

## Timing
- Enable and flush outputs are combinational from the current inputs and registered state, so they act in the same cycle.
- `state`, `wait_cnt`, `mem_timeout` and `stall_cycles` are registered.
- Reset values: state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0.
- While `rst`=1, all enables=1, both flushes=0, and the counters do not count.
- Reset asserted mid-WAIT returns the FSM to RUN on the next edge, regardless of `mem_ready`.
- A load-use hazard costs exactly 1 bubble.
- A memory access with `mem_ready` low for N cycles freezes the pipeline for exactly N cycles.
- `mem_ready`=1 in the same cycle the access enters MEM means 0 freeze cycles.

## Configuration
- MEM_WAIT_EN defined: `mem_ready` is honoured, and the FSM, `wait_cnt` and `mem_timeout` are built.
- MEM_WAIT_EN undefined: single-cycle memory is assumed.
  - `mem_ready` is ignored.
  - The FSM is held in RUN, and `mem_timeout` is tied to 0.
  - EX_MEM_Wr and ID_EX_Wr are tied to 1, and MEM_WB_Flush is tied to 0.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum (RUN, WAIT);
  - REG_ZERO (5'd0);
  - the register-index width (5).
- Sub-module `sat_counter`: parameterised width and max, with inc/clear inputs and synchronous active-high `rst`. It is used for both `wait_cnt` and `stall_cycles`.

## Test plan
- lw $8 in EX, add $9,$8,$10 in ID (UseRs) → ID_EX_Flush=1, PC_Wr=0 for 1 cycle; stall_cycles=1.
- lw $8 in EX, sw $8 in ID (D_MemWr=1, D_UseRt=1, D_UseRs=0) → no stall; all enables=1.
- lw $0 in EX, add reading $0 in ID → no stall.
- (MEM_WAIT_EN) M_MemRd=1, mem_ready low 3 cycles then high → freeze exactly 3 cycles with MEM_WB_Flush=1; then RUN; stall_cycles=3.
- (MEM_WAIT_EN, WAIT_MAX=4) mem_ready held low 6 cycles → mem_timeout rises after the 4th WAIT cycle and stays 1 after release; `rst` clears it.
- Freeze with a load-use pair pending, then `rst` asserted mid-WAIT → next cycle state=RUN and all counters 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline types and constants for the stall controller
package pipe_pkg;
  typedef enum logic {RUN, WAIT} state_t;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && cnt != MAX) cnt <= cnt + 1'b1;
endmodule

// File: rtl/load_use_stall_unit.sv
// load_use_stall_unit: load-use bubble and memory-wait freeze control (MEM_WAIT_EN builds the wait FSM)
module load_use_stall_unit
  import pipe_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] D_Rs,
  input  logic [REG_W-1:0] D_Rt,
  input  logic             D_UseRs,
  input  logic             D_UseRt,
  input  logic             D_MemWr,
  input  logic             E_MemRd,
  input  logic [REG_W-1:0] E_Rw,
  input  logic             M_MemRd,
  input  logic             M_MemWr,
  input  logic             mem_ready,
  output logic             PC_Wr,
  output logic             IF_ID_Wr,
  output logic             ID_EX_Flush,
  output logic             ID_EX_Wr,
  output logic             EX_MEM_Wr,
  output logic             MEM_WB_Flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);
  logic lu_hazard, freeze, bubble;
  assign lu_hazard = E_MemRd && E_Rw != REG_ZERO &&
                     ((D_UseRs && D_Rs == E_Rw) || (D_UseRt && !D_MemWr && D_Rt == E_Rw));
`ifdef MEM_WAIT_EN
  localparam int WAIT_W = $clog2(WAIT_MAX + 1) > 8 ? $clog2(WAIT_MAX + 1) : 8;
  state_t state, state_nx;
  logic mem_busy;
  logic [WAIT_W-1:0] wait_cnt;
  assign mem_busy = (M_MemRd || M_MemWr) && !mem_ready;
  always_ff @(posedge clk)
    state <= rst ? RUN : state_nx;
  always_comb begin
    state_nx = state;
    freeze = 1'b0;
    state_nx = state == RUN ? (mem_busy ? WAIT : RUN) : (mem_ready ? RUN : WAIT);
    freeze = !rst && (state == RUN ? mem_busy : !mem_ready);
  end
  sat_counter #(.W(WAIT_W), .MAX(WAIT_W'(WAIT_MAX))) u_wait_cnt (
    .clk(clk), .rst(rst), .inc(state == WAIT), .clr(state == RUN), .cnt(wait_cnt)
  );
  always_ff @(posedge clk)
    if (rst) mem_timeout <= 1'b0;
    else if (state == WAIT && 32'(wait_cnt) >= WAIT_MAX - 1) mem_timeout <= 1'b1;
`else
  logic unused_mem;
  assign unused_mem = &{mem_ready, M_MemRd, M_MemWr};
  assign freeze = 1'b0;
  assign mem_timeout = 1'b0;
`endif
  assign bubble = !rst && !freeze && lu_hazard;
  assign PC_Wr = !(freeze || bubble);
  assign IF_ID_Wr = !(freeze || bubble);
  assign ID_EX_Flush = bubble;
  assign ID_EX_Wr = !freeze;
  assign EX_MEM_Wr = !freeze;
  assign MEM_WB_Flush = freeze;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(freeze || bubble), .clr(1'b0), .cnt(stall_cycles)
  );
endmodule

// File: tb/tb_load_use_stall_unit.sv
// tb_load_use_stall_unit: directed checks of bubble, store exemption, freeze, timeout and reset
module tb_load_use_stall_unit;
  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] D_Rs, D_Rt, E_Rw;
  logic D_UseRs, D_UseRt, D_MemWr, E_MemRd, M_MemRd, M_MemWr, mem_ready;
  logic PC_Wr, IF_ID_Wr, ID_EX_Flush, ID_EX_Wr, EX_MEM_Wr, MEM_WB_Flush, mem_timeout;
  logic [3:0] stall_cycles;
  logic [5:0] outs;
  int total = 0, passed = 0;
  localparam logic [5:0] NORM = 6'b110110, BUB = 6'b001110, FRZ = 6'b000001;
  assign outs = {PC_Wr, IF_ID_Wr, ID_EX_Flush, ID_EX_Wr, EX_MEM_Wr, MEM_WB_Flush};
  load_use_stall_unit #(.WAIT_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .D_Rs(D_Rs), .D_Rt(D_Rt), .D_UseRs(D_UseRs), .D_UseRt(D_UseRt),
    .D_MemWr(D_MemWr), .E_MemRd(E_MemRd), .E_Rw(E_Rw), .M_MemRd(M_MemRd), .M_MemWr(M_MemWr),
    .mem_ready(mem_ready), .PC_Wr(PC_Wr), .IF_ID_Wr(IF_ID_Wr), .ID_EX_Flush(ID_EX_Flush),
    .ID_EX_Wr(ID_EX_Wr), .EX_MEM_Wr(EX_MEM_Wr), .MEM_WB_Flush(MEM_WB_Flush),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired, got %0d/%0d", passed, total);
    $fatal(1);
  end
  task tick;
    @(posedge clk);
    #1;
  endtask
  task idle;
    {D_Rs, D_Rt, E_Rw} = '0;
    {D_UseRs, D_UseRt, D_MemWr, E_MemRd, M_MemRd, M_MemWr} = '0;
    mem_ready = 1'b1;
  endtask
  task lw_add(input logic [4:0] rw, input logic [4:0] rs);
    idle();
    E_MemRd = 1'b1;
    E_Rw = rw;
    D_Rs = rs;
    D_UseRs = 1'b1;
    D_Rt = 5'd10;
    D_UseRt = 1'b1;
  endtask
  task do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task test_reset;
    lw_add(5'd8, 5'd8);
    rst = 1'b1;
    #1;
    total++; if (outs !== NORM) $display("FAIL reset_outs: got %b want %b", outs, NORM); else passed++;
    tick();
    rst = 1'b0;
    idle();
    #1;
    total++; if (stall_cycles !== 4'd0) $display("FAIL reset_stall: got %0d want 0", stall_cycles); else passed++;
    total++; if (mem_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", mem_timeout); else passed++;
    total++; if (outs !== NORM) $display("FAIL reset_idle_outs: got %b want %b", outs, NORM); else passed++;
  endtask
  task test_load_use;
    lw_add(5'd8, 5'd8);
    #1;
    total++; if (outs !== BUB) $display("FAIL lu_rs_outs: got %b want %b", outs, BUB); else passed++;
    tick();
    E_MemRd = 1'b0;
    #1;
    total++; if (outs !== NORM) $display("FAIL lu_after_bubble: got %b want %b", outs, NORM); else passed++;
    total++; if (stall_cycles !== 4'd1) $display("FAIL lu_stall_cnt: got %0d want 1", stall_cycles); else passed++;
    lw_add(5'd8, 5'd3);
    D_Rt = 5'd8;
    #1;
    total++; if (outs !== BUB) $display("FAIL lu_rt_outs: got %b want %b", outs, BUB); else passed++;
    tick();
    idle();
    #1;
    total++; if (stall_cycles !== 4'd2) $display("FAIL lu_rt_cnt: got %0d want 2", stall_cycles); else passed++;
  endtask
  task test_store_exempt;
    idle();
    E_MemRd = 1'b1;
    E_Rw = 5'd8;
    D_MemWr = 1'b1;
    D_UseRt = 1'b1;
    D_Rt = 5'd8;
    D_Rs = 5'd29;
    #1;
    total++; if (outs !== NORM) $display("FAIL sw_data_outs: got %b want %b", outs, NORM); else passed++;
    tick();
    total++; if (stall_cycles !== 4'd2) $display("FAIL sw_data_cnt: got %0d want 2", stall_cycles); else passed++;
    D_UseRs = 1'b1;
    D_Rs = 5'd8;
    #1;
    total++; if (outs !== BUB) $display("FAIL sw_base_outs: got %b want %b", outs, BUB); else passed++;
    tick();
    idle();
    #1;
    total++; if (stall_cycles !== 4'd3) $display("FAIL sw_base_cnt: got %0d want 3", stall_cycles); else passed++;
  endtask
  task test_no_hazard;
    lw_add(5'd0, 5'd0);
    #1;
    total++; if (outs !== NORM) $display("FAIL zero_reg_outs: got %b want %b", outs, NORM); else passed++;
    lw_add(5'd8, 5'd8);
    D_UseRs = 1'b0;
    #1;
    total++; if (outs !== NORM) $display("FAIL no_use_outs: got %b want %b", outs, NORM); else passed++;
    lw_add(5'd8, 5'd8);
    E_MemRd = 1'b0;
    #1;
    total++; if (outs !== NORM) $display("FAIL not_load_outs: got %b want %b", outs, NORM); else passed++;
    tick();
    total++; if (stall_cycles !== 4'd3) $display("FAIL no_hazard_cnt: got %0d want 3", stall_cycles); else passed++;
  endtask
  task test_saturate;
    lw_add(5'd5, 5'd5);
    for (int i = 0; i < 14; i++) tick();
    total++; if (stall_cycles !== 4'd15) $display("FAIL sat_cnt: got %0d want 15", stall_cycles); else passed++;
    total++; if (outs !== BUB) $display("FAIL sat_outs: got %b want %b", outs, BUB); else passed++;
    idle();
    do_reset();
    total++; if (stall_cycles !== 4'd0) $display("FAIL sat_reset: got %0d want 0", stall_cycles); else passed++;
  endtask
`ifdef MEM_WAIT_EN
  task test_mem_wait;
    idle();
    M_MemRd = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) lw_add(5'd7, 5'd7);
      M_MemRd = 1'b1;
      mem_ready = 1'b0;
      #1;
      total++; if (outs !== FRZ) $display("FAIL freeze_c%0d: got %b want %b", i, outs, FRZ); else passed++;
      tick();
    end
    mem_ready = 1'b1;
    #1;
    total++; if (outs !== BUB) $display("FAIL release_lu: got %b want %b", outs, BUB); else passed++;
    tick();
    idle();
    #1;
    total++; if (stall_cycles !== 4'd4) $display("FAIL wait_cnt_total: got %0d want 4", stall_cycles); else passed++;
    M_MemWr = 1'b1;
    #1;
    total++; if (outs !== NORM) $display("FAIL ready_same_cycle: got %b want %b", outs, NORM); else passed++;
    tick();
    total++; if (stall_cycles !== 4'd4) $display("FAIL ready_same_cnt: got %0d want 4", stall_cycles); else passed++;
  endtask
  task test_timeout;
    idle();
    do_reset();
    M_MemRd = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (mem_timeout !== 1'b1) $display("FAIL timeout_rise: got %b want 1", mem_timeout); else passed++;
    total++; if (outs !== FRZ) $display("FAIL timeout_frozen: got %b want %b", outs, FRZ); else passed++;
    tick();
    mem_ready = 1'b1;
    #1;
    total++; if (outs !== NORM) $display("FAIL timeout_release: got %b want %b", outs, NORM); else passed++;
    tick();
    idle();
    total++; if (mem_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", mem_timeout); else passed++;
    total++; if (stall_cycles !== 4'd6) $display("FAIL timeout_cnt: got %0d want 6", stall_cycles); else passed++;
    do_reset();
    total++; if (mem_timeout !== 1'b0) $display("FAIL timeout_clear: got %b want 0", mem_timeout); else passed++;
  endtask
  task test_reset_mid_wait;
    lw_add(5'd9, 5'd9);
    M_MemRd = 1'b1;
    mem_ready = 1'b0;
    tick();
    tick();
    total++; if (outs !== FRZ) $display("FAIL midwait_frozen: got %b want %b", outs, FRZ); else passed++;
    rst = 1'b1;
    #1;
    total++; if (outs !== NORM) $display("FAIL midwait_rst_outs: got %b want %b", outs, NORM); else passed++;
    tick();
    rst = 1'b0;
    M_MemRd = 1'b0;
    #1;
    total++; if (outs !== BUB) $display("FAIL midwait_run: got %b want %b", outs, BUB); else passed++;
    total++; if (stall_cycles !== 4'd0) $display("FAIL midwait_cnt: got %0d want 0", stall_cycles); else passed++;
    total++; if (mem_timeout !== 1'b0) $display("FAIL midwait_timeout: got %b want 0", mem_timeout); else passed++;
    idle();
  endtask
`else
  task test_mem_ignored;
    idle();
    M_MemRd = 1'b1;
    mem_ready = 1'b0;
    #1;
    total++; if (outs !== NORM) $display("FAIL mem_ignored_outs: got %b want %b", outs, NORM); else passed++;
    tick();
    tick();
    total++; if (stall_cycles !== 4'd0) $display("FAIL mem_ignored_cnt: got %0d want 0", stall_cycles); else passed++;
    total++; if (mem_timeout !== 1'b0) $display("FAIL mem_ignored_timeout: got %b want 0", mem_timeout); else passed++;
    idle();
  endtask
`endif
  initial begin
    idle();
    tick();
    test_reset();
    test_load_use();
    test_store_exempt();
    test_no_hazard();
    test_saturate();
`ifdef MEM_WAIT_EN
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
`else
    test_mem_ignored();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
